// File: rtl/ram_ctrl_pkg.sv
// Shared types and sizing constants for the RAM arbiter and its round-robin selector.
package ram_ctrl_pkg;

  localparam int unsigned DEPTH      = 128;
  localparam int unsigned ADDR_W     = $clog2(DEPTH);
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned RAM_ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin winner select; bit 0 is requester A, bit 1 is requester B.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt_c
);

  // last_grant = 1 means B won last, so A takes the next tie
  always_comb begin
    gnt_c = req;
    if (req == 2'b11) begin
      gnt_c = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Serialises two requesters onto a single-port RAM with round-robin arbitration
// and returns registered read data with a per-requester valid pulse.
module ram_arbiter #(
  parameter int unsigned ADDR_W     = ram_ctrl_pkg::ADDR_W,
  parameter int unsigned DATA_W     = ram_ctrl_pkg::DATA_W,
  parameter int unsigned RAM_ADDR_W = ram_ctrl_pkg::RAM_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_wr,
  input  logic [ADDR_W-1:0]     a_addr,
  input  logic [DATA_W-1:0]     a_wdata,
  input  logic                  b_req,
  input  logic                  b_wr,
  input  logic [ADDR_W-1:0]     b_addr,
  input  logic [DATA_W-1:0]     b_wdata,
  output logic                  a_gnt,
  output logic                  b_gnt,
  output logic                  a_rvalid,
  output logic                  b_rvalid,
  output logic [DATA_W-1:0]     rdata,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0]     ram_din,
  input  logic [DATA_W-1:0]     ram_dout,
  output logic                  busy
);

  import ram_ctrl_pkg::*;

  state_t                state_q, state_d;
  logic                  last_q, last_d;
  logic                  win_q, win_d;
  logic                  wr_q, wr_d;
  logic                  a_gnt_q, a_gnt_d;
  logic                  b_gnt_q, b_gnt_d;
  logic                  a_rv_q, a_rv_d;
  logic                  b_rv_q, b_rv_d;
  logic                  cs_q, cs_d;
  logic                  we_q, we_d;
  logic                  oe_q, oe_d;
  logic                  busy_q, busy_d;
  logic [RAM_ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     din_q, din_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [1:0]            pick_c;

  rr_arb2 u_rr_arb2 (
    .req        ({b_req, a_req}),
    .last_grant (last_q),
    .gnt_c      (pick_c)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    wr_d    = wr_q;
    a_gnt_d = 1'b0;
    b_gnt_d = 1'b0;
    a_rv_d  = 1'b0;
    b_rv_d  = 1'b0;
    cs_d    = 1'b0;
    we_d    = 1'b0;
    oe_d    = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;
    rdata_d = rdata_q;

    case (state_q)
      IDLE: begin
        if (|pick_c) begin
          win_d   = pick_c[1];
          last_d  = pick_c[1];
          a_gnt_d = pick_c[0];
          b_gnt_d = pick_c[1];
          wr_d    = pick_c[1] ? b_wr : a_wr;
          addr_d  = RAM_ADDR_W'(pick_c[1] ? b_addr : a_addr);
          din_d   = pick_c[1] ? b_wdata : a_wdata;
          cs_d    = 1'b1;
          we_d    = wr_d;
          oe_d    = ~wr_d;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        state_d = wr_q ? IDLE : CAPTURE;
      end
      CAPTURE: begin
        rdata_d = ram_dout;
        a_rv_d  = ~win_q;
        b_rv_d  = win_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      win_q   <= 1'b0;
      wr_q    <= 1'b0;
      a_gnt_q <= 1'b0;
      b_gnt_q <= 1'b0;
      a_rv_q  <= 1'b0;
      b_rv_q  <= 1'b0;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      wr_q    <= wr_d;
      a_gnt_q <= a_gnt_d;
      b_gnt_q <= b_gnt_d;
      a_rv_q  <= a_rv_d;
      b_rv_q  <= b_rv_d;
      cs_q    <= cs_d;
      we_q    <= we_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rdata_q <= rdata_d;
    end
  end

  assign a_gnt    = a_gnt_q;
  assign b_gnt    = b_gnt_q;
  assign a_rvalid = a_rv_q;
  assign b_rvalid = b_rv_q;
  assign rdata    = rdata_q;
  assign ram_cs   = cs_q;
  assign ram_we   = we_q;
  assign ram_oe   = oe_q;
  assign ram_addr = addr_q;
  assign ram_din  = din_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed table, corner sequences and
// randomized traffic scored against a transaction-level schedule model.
module tb_ram_arbiter;

  localparam int unsigned MAXC = 48;

  typedef struct packed {
    logic       wr;
    logic [6:0] addr;
    logic [7:0] wdata;
  } txn_t;

  typedef struct {
    bit         a_en;
    txn_t       a;
    bit         b_en;
    txn_t       b;
    logic       exp_first_b;
    logic [7:0] exp_rd_a;
    logic [7:0] exp_rd_b;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_req, a_wr, b_req, b_wr;
  logic [6:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [7:0] rdata;
  logic       ram_cs, ram_we, ram_oe;
  logic [7:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout = 8'h00;
  logic       busy;

  always #5 clk = ~clk;

  ram_arbiter u_dut (
    .clk      (clk),
    .reset    (reset),
    .a_req    (a_req),
    .a_wr     (a_wr),
    .a_addr   (a_addr),
    .a_wdata  (a_wdata),
    .b_req    (b_req),
    .b_wr     (b_wr),
    .b_addr   (b_addr),
    .b_wdata  (b_wdata),
    .a_gnt    (a_gnt),
    .b_gnt    (b_gnt),
    .a_rvalid (a_rvalid),
    .b_rvalid (b_rvalid),
    .rdata    (rdata),
    .ram_cs   (ram_cs),
    .ram_we   (ram_we),
    .ram_oe   (ram_oe),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout),
    .busy     (busy)
  );

  // 128 x 8 single-port RAM with registered read data
  logic [7:0] ram_mem [128] = '{default: 8'h00};
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) ram_mem[ram_addr[6:0]] <= ram_din;
      if (ram_oe) ram_dout <= ram_mem[ram_addr[6:0]];
    end
  end

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] mdl_mem [128] = '{default: 8'h00};
  logic       mdl_last;
  txn_t       qa[$];
  txn_t       qb[$];
  // expected per-cycle flags: {a_gnt,b_gnt,a_rvalid,b_rvalid,cs,we,oe,busy}
  logic [7:0] e_flags [MAXC];
  logic [7:0] e_addr  [MAXC];
  logic [7:0] e_din   [MAXC];
  logic [7:0] e_rd    [MAXC];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {a_gnt, b_gnt, a_rvalid, b_rvalid, ram_cs, ram_we, ram_oe, busy,
            ram_addr, ram_din, rdata};
  endfunction

  function automatic txn_t mk(input logic wr, input logic [6:0] addr, input logic [7:0] d);
    txn_t x;
    x.wr = wr; x.addr = addr; x.wdata = d;
    return x;
  endfunction

  function automatic txn_t rnd_txn();
    int s;
    s = int'($urandom_range(0, 8));
    return mk(1'($urandom_range(0, 1)), (s == 8) ? 7'h7F : 7'(s), 8'($urandom));
  endfunction

  task automatic drive();
    a_req = (qa.size() > 0);
    if (qa.size() > 0) begin
      a_wr = qa[0].wr; a_addr = qa[0].addr; a_wdata = qa[0].wdata;
    end
    b_req = (qb.size() > 0);
    if (qb.size() > 0) begin
      b_wr = qb[0].wr; b_addr = qb[0].addr; b_wdata = qb[0].wdata;
    end
  endtask

  // Schedules qa/qb by the round-robin rule, then runs the DUT cycle by cycle
  task automatic run_scn(input string tag, output logic first_b,
                         output logic [7:0] rd_a, output logic [7:0] rd_b);
    txn_t ma[$];
    txn_t mb[$];
    txn_t x;
    logic w;
    logic seen;
    int   t;
    logic [7:0] act;
    ma = qa; mb = qb;
    for (int k = 0; k < int'(MAXC); k++) begin
      e_flags[k] = 8'h00; e_addr[k] = 8'h00; e_din[k] = 8'h00; e_rd[k] = 8'h00;
    end
    t = 0;
    while ((ma.size() > 0 || mb.size() > 0) && t + 4 < int'(MAXC)) begin
      if (ma.size() > 0 && mb.size() > 0) w = ~mdl_last;
      else w = (ma.size() == 0);
      if (w) x = mb.pop_front(); else x = ma.pop_front();
      mdl_last = w;
      e_flags[t] = {~w, w, 2'b00, 1'b1, x.wr, ~x.wr, 1'b1};
      e_addr[t]  = {1'b0, x.addr};
      e_din[t]   = x.wdata;
      if (x.wr) begin
        mdl_mem[x.addr] = x.wdata;
        t += 2;
      end else begin
        e_flags[t+1] = 8'h01;
        e_flags[t+2] = {2'b00, ~w, w, 4'b0000};
        e_rd[t+2]    = mdl_mem[x.addr];
        t += 3;
      end
    end
    first_b = 1'bx; rd_a = 8'hxx; rd_b = 8'hxx; seen = 1'b0;
    drive();
    for (int k = 0; k <= t + 1; k++) begin
      @(posedge clk); #1;
      act = {a_gnt, b_gnt, a_rvalid, b_rvalid, ram_cs, ram_we, ram_oe, busy};
      chk($sformatf("%s c%0d flags", tag, k), 32'(act), 32'(e_flags[k]));
      chk($sformatf("%s c%0d onehot", tag, k), 32'({a_gnt & b_gnt, a_rvalid & b_rvalid}), 32'(0));
      if (e_flags[k][3]) begin
        chk($sformatf("%s c%0d ram_addr", tag, k), 32'(ram_addr), 32'(e_addr[k]));
        chk($sformatf("%s c%0d ram_din", tag, k), 32'(ram_din), 32'(e_din[k]));
      end
      if (e_flags[k][5] || e_flags[k][4])
        chk($sformatf("%s c%0d rdata", tag, k), 32'(rdata), 32'(e_rd[k]));
      if (!seen && (a_gnt || b_gnt)) begin
        first_b = b_gnt; seen = 1'b1;
      end
      if (a_rvalid) rd_a = rdata;
      if (b_rvalid) rd_b = rdata;
      if (a_gnt && qa.size() > 0) void'(qa.pop_front());
      if (b_gnt && qb.size() > 0) void'(qb.pop_front());
      drive();
    end
    chk({tag, " drain"}, 32'(qa.size() + qb.size()), 32'(0));
    qa.delete(); qb.delete();
    drive();
  endtask

  vec_t       tbl [7];
  logic       fb;
  logic [7:0] ra, rb;
  int         na, nb;

  initial begin
    reset = 1'b0;
    a_req = 1'b0; a_wr = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0;
    mdl_last = 1'b1;

    tbl[0] = '{1'b1, mk(1'b1, 7'h05, 8'hA5), 1'b0, mk(1'b0, 7'h00, 8'h00), 1'b0, 8'h00, 8'h00};
    tbl[1] = '{1'b1, mk(1'b0, 7'h05, 8'h00), 1'b0, mk(1'b0, 7'h00, 8'h00), 1'b0, 8'hA5, 8'h00};
    tbl[2] = '{1'b0, mk(1'b0, 7'h00, 8'h00), 1'b1, mk(1'b1, 7'h7F, 8'hFF), 1'b1, 8'h00, 8'h00};
    tbl[3] = '{1'b1, mk(1'b1, 7'h30, 8'h3C), 1'b1, mk(1'b0, 7'h30, 8'h00), 1'b0, 8'h00, 8'h3C};
    tbl[4] = '{1'b1, mk(1'b0, 7'h7F, 8'h00), 1'b0, mk(1'b0, 7'h00, 8'h00), 1'b0, 8'hFF, 8'h00};
    tbl[5] = '{1'b1, mk(1'b1, 7'h10, 8'h11), 1'b0, mk(1'b0, 7'h00, 8'h00), 1'b0, 8'h00, 8'h00};
    tbl[6] = '{1'b0, mk(1'b0, 7'h00, 8'h00), 1'b1, mk(1'b1, 7'h20, 8'h22), 1'b1, 8'h00, 8'h00};

    // Reset held for three cycles, then idle: everything stays at zero
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("reset c%0d outs", k), all_outs(), 32'(0));
    end
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("idle c%0d outs", k), all_outs(), 32'(0));
    end

    // Directed table
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].a_en) qa.push_back(tbl[i].a);
      if (tbl[i].b_en) qb.push_back(tbl[i].b);
      run_scn($sformatf("vec%0d", i), fb, ra, rb);
      chk($sformatf("vec%0d first_grant", i), 32'(fb), 32'(tbl[i].exp_first_b));
      if (tbl[i].a_en && !tbl[i].a.wr)
        chk($sformatf("vec%0d rd_a", i), 32'(ra), 32'(tbl[i].exp_rd_a));
      if (tbl[i].b_en && !tbl[i].b.wr)
        chk($sformatf("vec%0d rd_b", i), 32'(rb), 32'(tbl[i].exp_rd_b));
    end

    // Contention: both hold req for four reads each, grants alternate A,B,...
    for (int i = 0; i < 4; i++) begin
      qa.push_back(mk(1'b0, 7'h10, 8'h00));
      qb.push_back(mk(1'b0, 7'h20, 8'h00));
    end
    run_scn("contend", fb, ra, rb);
    chk("contend first_grant", 32'(fb), 32'(0));
    chk("contend rd_a", 32'(ra), 32'(8'h11));
    chk("contend rd_b", 32'(rb), 32'(8'h22));

    // Reset during CAPTURE aborts the read and restores the A-favoured pointer
    a_req = 1'b1; a_wr = 1'b0; a_addr = 7'h05;
    @(posedge clk); #1;
    chk("midrst gnt", 32'(a_gnt), 32'(1));
    a_req = 1'b0;
    @(posedge clk); #1;
    chk("midrst capture", 32'({busy, ram_cs, a_rvalid}), 32'(3'b100));
    reset = 1'b0;
    #1;
    chk("midrst abort", all_outs(), 32'(0));
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk($sformatf("midrst hold c%0d", k), all_outs(), 32'(0));
    end
    reset = 1'b1;
    mdl_last = 1'b1;
    qa.push_back(mk(1'b1, 7'h40, 8'h44));
    qb.push_back(mk(1'b1, 7'h41, 8'h55));
    run_scn("postrst", fb, ra, rb);
    chk("postrst first_grant", 32'(fb), 32'(0));

    // Randomized traffic against the schedule model
    for (int r = 0; r < 16; r++) begin
      na = int'($urandom_range(0, 3));
      nb = int'($urandom_range(0, 3));
      if (na + nb == 0) na = 1;
      for (int i = 0; i < na; i++) qa.push_back(rnd_txn());
      for (int i = 0; i < nb; i++) qb.push_back(rnd_txn());
      run_scn($sformatf("rnd%0d", r), fb, ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port round-robin arbiter and sequencer for the 128 x 8 single-port RAM. It accepts independent read/write requests from two requesters, A and B, and serialises them onto the RAM strobes (cs, we, oe, address, data_in). It captures read data from the RAM's registered data_out and returns it to the winning requester with a valid pulse. It sits directly in front of the RAM instance; requesters never drive the RAM themselves.

## Interface
Parameters:
- ADDR_W, 7: requester address width (128 words).
- DATA_W, 8: data width.
- RAM_ADDR_W, 8: RAM address port width; upper bits are driven 0.

Ports:
- clk  in  1  single clock for the block and the RAM.
- reset  in  1  asynchronous, active-low reset.
- a_req, b_req  in  1  request; held high with fields stable until the matching gnt.
- a_wr, b_wr  in  1  1 = write, 0 = read.
- a_addr, b_addr  in  ADDR_W  word address.
- a_wdata, b_wdata  in  DATA_W  write data.
- a_gnt, b_gnt  out  1  one-cycle grant pulse; the request is accepted.
- a_rvalid, b_rvalid  out  1  one-cycle pulse; rdata valid for that requester.
- rdata  out  DATA_W  read data, shared by both ports and qualified by *_rvalid.
- ram_cs, ram_we, ram_oe  out  1  RAM strobes.
- ram_addr  out  RAM_ADDR_W  RAM address.
- ram_din  out  DATA_W  RAM write data.
- ram_dout  in  DATA_W  RAM read data.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states:
  - IDLE: no access in progress.
  - ACCESS: RAM strobes asserted for one cycle.
  - CAPTURE: reads only; waits for ram_dout.
- IDLE:
  - With no request, stay in IDLE.
  - With any request, choose a winner, assert its gnt, and load the strobes and fields. Go to ACCESS.
- Strobes during ACCESS: ram_cs=1; ram_we=wr; ram_oe=!wr; ram_addr={0,addr}; ram_din=wdata.
- ACCESS:
  - For a write, go to IDLE.
  - For a read, go to CAPTURE.
  - In both cases, drop ram_cs, ram_we and ram_oe to 0.
- CAPTURE: register ram_dout into rdata, pulse the winner's rvalid, go to IDLE.
- Arbitration:
  - Round-robin with a one-bit last_grant pointer.
  - If only one port requests, that port wins.
  - If both request, the port that was not granted last wins.
  - The pointer updates on every grant.
  - After reset the pointer favours A.
- A requester can drop req on the cycle after its gnt. A req still high after its gnt is a new request.
- ram_addr, ram_din and rdata hold their last value outside ACCESS/CAPTURE; only the strobes are guaranteed 0.

## Timing
- Reset values: all outputs 0. State = IDLE, last_grant = B (so A wins the first tie), rdata = 0.
- Asserting reset mid-operation aborts immediately:
  - strobes return to 0;
  - no gnt or rvalid is produced for the in-flight access;
  - a write strobed at the same edge as reset assertion is not guaranteed to complete.
- Edge E0 (IDLE, req sampled high): gnt is high during E0–E1, and the strobes are high during E0–E1.
- Edge E1: the RAM performs the access.
  - For a write, the data is in the RAM after E1; busy drops after E1.
  - For a read, ram_dout is valid after E1.
- Edge E2 (read only): rdata is loaded and rvalid is high during E2–E3.
- Latency from req sampled to rvalid: 2 cycles.
- Throughput: one write per 2 cycles and one read per 3 cycles. A new grant is possible at the edge where the FSM is in IDLE.
- Requests arriving while busy are ignored until IDLE; requesters must hold req.
- At most one gnt and at most one rvalid are high in any cycle.
- A simultaneous write and read to the same address from A and B are serialised in grant order; the read returns whichever value was written first.

## Structure
- Package ram_ctrl_pkg holds:
  - typedef enum state_t {IDLE, ACCESS, CAPTURE};
  - constants DEPTH=128, ADDR_W, DATA_W, RAM_ADDR_W.
- Sub-module rr_arb2:
  - combinational 2-way round-robin winner select from req[1:0] and last_grant;
  - outputs a one-hot grant.
  - ram_arbiter owns the pointer register and the FSM.
- A testbench top wires ram_arbiter to the RAM through the existing RAM interface bundle and shares clk.

## Test plan
- Reset then idle: reset low for 3 cycles, no requests → all outputs 0, busy=0, ram_cs never high.
- Single write then read:
  - stimulus: A writes addr 0x05 data 0xA5, then A reads 0x05.
  - response: a_gnt at E0; ram_cs=1, ram_we=1 for one cycle; a_rvalid 2 cycles after the read gnt with rdata=0xA5.
- Contention fairness:
  - stimulus: A and B hold req continuously, reads of 0x10 and 0x20 preloaded with 0x11 and 0x22.
  - response: grants alternate A, B, A, B; rvalid data alternates 0x11, 0x22; no two gnt in one cycle.
- Boundary address: write 0x7F data 0xFF from B, read back from A → rdata=0xFF, ram_addr=0x7F with MSB 0.
- Same-address race:
  - stimulus: at one edge, A writes 0x30 with 0x3C and B reads 0x30 (old value 0x00).
  - response: A granted first; B's rvalid returns 0x3C.
- Reset mid-read: assert reset during CAPTURE → no rvalid, strobes 0 immediately, next request after release granted to A on a tie.
